// File: rtl/lcd_write_arbiter_if.sv
// Requester-side bus of the LCD write arbiter.
// Two requesters share it. The arbiter answers with ack pulses and a busy flag.
interface lcd_write_arbiter_if;
    logic       req0;
    logic       req1;
    logic       rs0;
    logic       rs1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       busy;

    modport master (
        output req0, req1, rs0, rs1, data0, data1,
        input  ack0, ack1, busy
    );

    modport slave (
        input  req0, req1, rs0, rs1, data0, data1,
        output ack0, ack1, busy
    );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter that lets two requesters share one HD44780-style LCD write port.
// Each write runs through the sequence setup, enable pulse, hold and then an execution wait.
module lcd_write_arbiter #(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_CYC        = 15,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned WAIT_CYC      = 2000,
    parameter int unsigned LONG_WAIT_CYC = 82000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    lcd_write_arbiter_if.slave  bus,
    input  logic                disp_on,
    output logic [7:0]          LCD_DATA,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic                LCD_EN,
    output logic                LCD_ON,
    output logic                LCD_BLON
);

    localparam int unsigned SETUP_L = (SETUP_CYC     == 0) ? 32'd1 : SETUP_CYC;
    localparam int unsigned EN_L    = (EN_CYC        == 0) ? 32'd1 : EN_CYC;
    localparam int unsigned HOLD_L  = (HOLD_CYC      == 0) ? 32'd1 : HOLD_CYC;
    localparam int unsigned WAIT_L  = (WAIT_CYC      == 0) ? 32'd1 : WAIT_CYC;
    localparam int unsigned LONG_L  = (LONG_WAIT_CYC == 0) ? 32'd1 : LONG_WAIT_CYC;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        last_grant;
    logic        grant_id;
    logic        is_long;
    logic [7:0]  lat_data;
    logic        lat_rs;
    logic        en_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        busy_q;
    logic        on_q;

    logic        pick1;
    logic        sel_rs;
    logic [7:0]  sel_data;
    logic        sel_long;
    logic [31:0] wait_len;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was granted last.
    always_comb begin
        pick1    = bus.req1 && (!bus.req0 || !last_grant);
        sel_rs   = pick1 ? bus.rs1 : bus.rs0;
        sel_data = pick1 ? bus.data1 : bus.data0;
        sel_long = !sel_rs && (sel_data[7:2] == 6'd0);
        wait_len = is_long ? LONG_L : WAIT_L;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            is_long    <= 1'b0;
            lat_data   <= 8'd0;
            lat_rs     <= 1'b0;
            en_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state      <= SETUP;
                        cnt        <= SETUP_L;
                        grant_id   <= pick1;
                        last_grant <= pick1;
                        lat_rs     <= sel_rs;
                        lat_data   <= sel_data;
                        is_long    <= sel_long;
                        busy_q     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 32'd1) begin
                        state <= PULSE;
                        cnt   <= EN_L;
                        en_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 32'd1) begin
                        state <= HOLD;
                        cnt   <= HOLD_L;
                        en_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 32'd1) begin
                        state <= WAIT;
                        cnt   <= wait_len;
                        if (wait_len == 32'd1) begin
                            ack0_q <= !grant_id;
                            ack1_q <= grant_id;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                WAIT: begin
                    // The ack is registered, so it is launched one cycle ahead to land on the last wait cycle.
                    if (cnt == 32'd1) begin
                        state  <= IDLE;
                        cnt    <= 32'd0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 32'd1;
                        if (cnt == 32'd2) begin
                            ack0_q <= !grant_id;
                            ack1_q <= grant_id;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= 32'd0;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            on_q <= 1'b0;
        end else begin
            on_q <= disp_on;
        end
    end

    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.busy = busy_q;
    assign LCD_DATA = lat_data;
    assign LCD_RS   = lat_rs;
    assign LCD_EN   = en_q;
    assign LCD_ON   = on_q;
    assign LCD_RW   = 1'b0;
    assign LCD_BLON = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with shortened wait counts.
// Expected latencies are computed from the bench parameters: 4+15+2+20 = 41 and 4+15+2+50 = 71.
module tb_lcd_write_arbiter;

    localparam int SETUP_P = 4;
    localparam int EN_P    = 15;
    localparam int HOLD_P  = 2;
    localparam int WAIT_P  = 20;
    localparam int LONG_P  = 50;
    localparam int LAT     = SETUP_P + EN_P + HOLD_P + WAIT_P;
    localparam int LAT_L   = SETUP_P + EN_P + HOLD_P + LONG_P;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       disp_on;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int pinViolations = 0;

    lcd_write_arbiter_if bus ();

    lcd_write_arbiter #(
        .SETUP_CYC(SETUP_P), .EN_CYC(EN_P), .HOLD_CYC(HOLD_P),
        .WAIT_CYC(WAIT_P), .LONG_WAIT_CYC(LONG_P)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus), .disp_on(disp_on),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Safety net so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic who, input logic rs, input logic [7:0] data);
        if (!who) begin
            bus.req0 = 1'b1; bus.rs0 = rs; bus.data0 = data;
        end else begin
            bus.req1 = 1'b1; bus.rs1 = rs; bus.data1 = data;
        end
    endtask

    // Cycle 1 is the negedge after the granting posedge; returns -1 in ackCyc on timeout.
    task automatic waitAck(input int budget, input int changeAt, input logic [7:0] newData,
                           output int ackCyc, output int enFirst, output int enLen,
                           output logic [1:0] ackBits, output logic busyFirst);
        ackCyc = -1; enFirst = -1; enLen = 0; ackBits = 2'b00; busyFirst = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge CLOCK_50);
            if (c == 1) busyFirst = bus.busy;
            if (c == changeAt) bus.data0 = newData;
            if (LCD_RW !== 1'b0 || LCD_BLON !== 1'b0) pinViolations++;
            if (LCD_EN === 1'b1) begin
                if (enFirst < 0) enFirst = c;
                enLen++;
            end
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                ackCyc  = c;
                ackBits = {bus.ack1, bus.ack0};
                break;
            end
        end
    endtask

    int         ackCyc, enFirst, enLen;
    logic [1:0] ackBits;
    logic       busyFirst;
    int         seen0, seen1;
    logic [1:0] expWho [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        reset = 1'b1; disp_on = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rs0 = 1'b0; bus.rs1 = 1'b0;
        bus.data0 = 8'd0; bus.data1 = 8'd0;
        repeat (2) @(negedge CLOCK_50);
        checkOutput("reset_outputs", {LCD_EN, LCD_RS, LCD_DATA, LCD_ON, bus.ack0, bus.ack1, bus.busy}, 32'd0);
        checkOutput("reset_pins", {LCD_RW, LCD_BLON}, 32'd0);

        reset = 1'b0;
        disp_on = 1'b1;
        #1;
        checkOutput("lcd_on_not_yet", LCD_ON, 32'd0);
        @(negedge CLOCK_50);
        checkOutput("lcd_on_registered", LCD_ON, 32'd1);
        checkOutput("idle_busy_low", bus.busy, 32'd0);

        // Plain character write from requester 0.
        applyStimulus(1'b0, 1'b1, 8'h43);
        waitAck(200, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("char_ack_cycle", ackCyc, LAT);
        checkOutput("char_ack_who", ackBits, 2'b01);
        checkOutput("char_en_first", enFirst, SETUP_P + 1);
        checkOutput("char_en_len", enLen, EN_P);
        checkOutput("char_busy_start", busyFirst, 32'd1);
        checkOutput("char_data", LCD_DATA, 8'h43);
        checkOutput("char_rs", LCD_RS, 32'd1);
        bus.req0 = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("char_busy_after", bus.busy, 32'd0);
        checkOutput("char_ack_one_cycle", {bus.ack1, bus.ack0}, 32'd0);

        // Clear display command takes the long wait; the boundary cases follow.
        applyStimulus(1'b1, 1'b0, 8'h01);
        waitAck(300, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("clear_ack_cycle", ackCyc, LAT_L);
        checkOutput("clear_ack_who", ackBits, 2'b10);
        bus.req1 = 1'b0;
        @(negedge CLOCK_50);
        applyStimulus(1'b1, 1'b0, 8'h03);
        waitAck(300, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("home_ack_cycle", ackCyc, LAT_L);
        bus.req1 = 1'b0;
        @(negedge CLOCK_50);
        applyStimulus(1'b1, 1'b0, 8'h04);
        waitAck(300, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("cmd04_ack_cycle", ackCyc, LAT);
        bus.req1 = 1'b0;
        @(negedge CLOCK_50);
        applyStimulus(1'b1, 1'b0, 8'h0F);
        waitAck(300, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("cmd0f_ack_cycle", ackCyc, LAT);
        checkOutput("cmd0f_data", LCD_DATA, 8'h0F);
        checkOutput("cmd0f_rs", LCD_RS, 32'd0);
        bus.req1 = 1'b0;
        @(negedge CLOCK_50);
        applyStimulus(1'b1, 1'b1, 8'h30);
        waitAck(300, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("char_rs1_ack_cycle", ackCyc, LAT);
        bus.req1 = 1'b0;
        @(negedge CLOCK_50);

        // Input data changing mid-pulse must not reach the panel.
        applyStimulus(1'b0, 1'b1, 8'h48);
        waitAck(200, 10, 8'h55, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("stable_ack_cycle", ackCyc, LAT);
        checkOutput("stable_data_at_ack", LCD_DATA, 8'h48);
        bus.req0 = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("stable_data_idle", LCD_DATA, 8'h48);
        bus.req0 = 1'b1;
        waitAck(200, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("new_data_sent", LCD_DATA, 8'h55);
        checkOutput("new_data_ack_who", ackBits, 2'b01);
        bus.req0 = 1'b0;
        @(negedge CLOCK_50);

        // Reset while idle: the round-robin pointer must favour requester 0 again.
        reset = 1'b1;
        #1;
        checkOutput("idle_reset_data", {LCD_RS, LCD_DATA}, 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        bus.rs0 = 1'b1; bus.data0 = 8'h30; bus.rs1 = 1'b1; bus.data1 = 8'h31;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        seen0 = 0; seen1 = 0;
        for (int i = 0; i < 4; i++) begin
            waitAck(200, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
            checkOutput($sformatf("tie_who_%0d", i), ackBits, expWho[i]);
            checkOutput($sformatf("tie_cycle_%0d", i), ackCyc, (i == 0) ? LAT : LAT + 1);
            checkOutput($sformatf("tie_data_%0d", i), LCD_DATA, (expWho[i] == 2'b01) ? 8'h30 : 8'h31);
            if (ackBits == 2'b01) seen0++;
            if (ackBits == 2'b10) seen1++;
            if (seen0 >= 2) bus.req0 = 1'b0;
            if (seen1 >= 2) bus.req1 = 1'b0;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge CLOCK_50);

        // Reset during the enable pulse aborts the write with no ack.
        applyStimulus(1'b0, 1'b1, 8'h5A);
        repeat (SETUP_P + 4) @(negedge CLOCK_50);
        checkOutput("abort_en_before", LCD_EN, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_en_now", LCD_EN, 32'd0);
        checkOutput("abort_busy_ack", {bus.busy, bus.ack1, bus.ack0}, 32'd0);
        checkOutput("abort_data_cleared", LCD_DATA, 32'd0);
        bus.req0 = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("abort_stays_idle", {bus.busy, bus.ack1, bus.ack0, LCD_EN}, 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h41);
        waitAck(200, 0, 8'h00, ackCyc, enFirst, enLen, ackBits, busyFirst);
        checkOutput("post_abort_ack_cycle", ackCyc, LAT);
        checkOutput("post_abort_ack_who", ackBits, 2'b10);
        checkOutput("post_abort_data", LCD_DATA, 8'h41);
        bus.req1 = 1'b0;
        @(negedge CLOCK_50);

        checkOutput("rw_blon_constant", pinViolations, 32'd0);
        checkOutput("lcd_on_held", LCD_ON, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
